// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit accumulator CPU: opcodes, ALU operation
// encodings, control FSM state encoding and the control strobe bundle.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_PASS_B = 3'd0;
    localparam logic [2:0] ALU_ADD    = 3'd1;
    localparam logic [2:0] ALU_SUB    = 3'd2;
    localparam logic [2:0] ALU_AND    = 3'd3;
    localparam logic [2:0] ALU_OR     = 3'd4;
    localparam logic [2:0] ALU_XOR    = 3'd5;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_LOAD_IR = 4'd1,
        ST_DECODE  = 4'd2,
        ST_MEM_RD  = 4'd3,
        ST_EXEC    = 4'd4,
        ST_MEM_WR  = 4'd5,
        ST_JUMP    = 4'd6,
        ST_HALT    = 4'd7,
        ST_FAULT   = 4'd8
    } ctrl_state_e;

    typedef struct packed {
        logic       load_ir;
        logic       inc_pc;
        logic       load_pc;
        logic       addr_sel;
        logic       mem_rd;
        logic       mem_wr;
        logic       load_acc;
        logic [2:0] alu_op;
        logic       halted;
        logic       fault;
    } ctrl_out_t;

    // Opcode to ALU operation; LDA (and anything non-arithmetic) passes the memory operand.
    function automatic logic [2:0] alu_op_of(input logic [3:0] op);
        logic [2:0] res;
        case (op)
            OP_ADD:  res = ALU_ADD;
            OP_SUB:  res = ALU_SUB;
            OP_AND:  res = ALU_AND;
            OP_OR:   res = ALU_OR;
            OP_XOR:  res = ALU_XOR;
            default: res = ALU_PASS_B;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory wait-state counter: counts stalled cycles of the current memory request
// and flags the last permitted wait cycle before a timeout.
module ctrl_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt_r;

    // Wait counter register, cleared whenever no request is stalling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (count_en) begin
            wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    assign expired = (wait_cnt_r == LAST_WAIT);

endmodule

// File: rtl/ctrl_unit.sv
// Multi-cycle fetch/decode/execute control FSM for the accumulator CPU, with a
// bounded memory wait-state timeout and registered Moore strobes.
module ctrl_unit
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       acc_zero,
    input  logic       mem_ready,
    output logic       load_ir,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       addr_sel,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       load_acc,
    output logic [2:0] alu_op,
    output logic       halted,
    output logic       fault
);

    ctrl_state_e state_r;
    ctrl_state_e next_state_s;
    ctrl_out_t   out_r;
    ctrl_out_t   out_nxt_s;

    logic mem_state_s;
    logic req_s;
    logic mem_done_s;
    logic wait_active_s;
    logic expired_s;

    // A request only counts once its strobe is visible, which covers the first
    // FETCH cycle after reset where the strobes are still cleared.
    assign mem_state_s   = (state_r == ST_FETCH) || (state_r == ST_MEM_RD) || (state_r == ST_MEM_WR);
    assign req_s         = out_r.mem_rd | out_r.mem_wr;
    assign mem_done_s    = mem_state_s & req_s & mem_ready;
    assign wait_active_s = mem_state_s & req_s & ~mem_ready;

    ctrl_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (~wait_active_s),
        .count_en (wait_active_s & ~expired_s),
        .expired  (expired_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; completion beats timeout when both land on the same cycle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_FETCH, ST_MEM_RD, ST_MEM_WR: begin
                if (mem_done_s) begin
                    if (state_r == ST_FETCH) begin
                        next_state_s = ST_LOAD_IR;
                    end else if (state_r == ST_MEM_RD) begin
                        next_state_s = ST_EXEC;
                    end else begin
                        next_state_s = ST_FETCH;
                    end
                end else if (wait_active_s && expired_s) begin
                    next_state_s = ST_FAULT;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_LOAD_IR: next_state_s = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_NOP: next_state_s = ST_FETCH;
                    OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: next_state_s = ST_MEM_RD;
                    OP_STA: next_state_s = ST_MEM_WR;
                    OP_JMP: next_state_s = ST_JUMP;
                    OP_JZ: begin
                        if (acc_zero) begin
                            next_state_s = ST_JUMP;
                        end else begin
                            next_state_s = ST_FETCH;
                        end
                    end
                    OP_HLT:  next_state_s = ST_HALT;
                    default: next_state_s = ST_FAULT;
                endcase
            end
            ST_EXEC:  next_state_s = ST_FETCH;
            ST_JUMP:  next_state_s = ST_FETCH;
            ST_HALT:  next_state_s = ST_HALT;
            ST_FAULT: next_state_s = ST_FAULT;
            default:  next_state_s = ST_FAULT;
        endcase
    end

    // Strobes decoded from the upcoming state so they are registered alongside it.
    always_comb begin
        out_nxt_s = '0;
        case (next_state_s)
            ST_FETCH: begin
                out_nxt_s.mem_rd = 1'b1;
            end
            ST_LOAD_IR: begin
                out_nxt_s.load_ir = 1'b1;
                out_nxt_s.inc_pc  = 1'b1;
            end
            ST_MEM_RD: begin
                out_nxt_s.mem_rd   = 1'b1;
                out_nxt_s.addr_sel = 1'b1;
            end
            ST_EXEC: begin
                out_nxt_s.load_acc = 1'b1;
                out_nxt_s.alu_op   = alu_op_of(opcode);
            end
            ST_MEM_WR: begin
                out_nxt_s.mem_wr   = 1'b1;
                out_nxt_s.addr_sel = 1'b1;
            end
            ST_JUMP:  out_nxt_s.load_pc = 1'b1;
            ST_HALT:  out_nxt_s.halted  = 1'b1;
            ST_FAULT: out_nxt_s.fault   = 1'b1;
            default:  out_nxt_s = '0;
        endcase
    end

    // Output register; reset drops any in-flight request immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r <= '0;
        end else begin
            out_r <= out_nxt_s;
        end
    end

    assign load_ir  = out_r.load_ir;
    assign inc_pc   = out_r.inc_pc;
    assign load_pc  = out_r.load_pc;
    assign addr_sel = out_r.addr_sel;
    assign mem_rd   = out_r.mem_rd;
    assign mem_wr   = out_r.mem_wr;
    assign load_acc = out_r.load_acc;
    assign alu_op   = out_r.alu_op;
    assign halted   = out_r.halted;
    assign fault    = out_r.fault;

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed self-checking bench for ctrl_unit: program trace, wait states,
// timeout boundary, conditional jump, illegal opcode and mid-transaction reset.
module tb_ctrl_unit;

    // Packed strobe words: {load_ir,inc_pc,load_pc,addr_sel,mem_rd,mem_wr,load_acc,halted,fault,alu_op}
    localparam logic [11:0] X_F   = 12'h080;
    localparam logic [11:0] X_L   = 12'hC00;
    localparam logic [11:0] X_D   = 12'h000;
    localparam logic [11:0] X_R   = 12'h180;
    localparam logic [11:0] X_W   = 12'h140;
    localparam logic [11:0] X_J   = 12'h200;
    localparam logic [11:0] X_H   = 12'h010;
    localparam logic [11:0] X_FLT = 12'h008;
    localparam logic [11:0] X_EPB = 12'h020;
    localparam logic [11:0] X_EAD = 12'h021;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       acc_zero;
    logic       mem_ready;
    logic       load_ir, inc_pc, load_pc, addr_sel, mem_rd, mem_wr, load_acc, halted, fault;
    logic [2:0] alu_op;
    logic [11:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    ctrl_unit #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .acc_zero  (acc_zero),
        .mem_ready (mem_ready),
        .load_ir   (load_ir),
        .inc_pc    (inc_pc),
        .load_pc   (load_pc),
        .addr_sel  (addr_sel),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .load_acc  (load_acc),
        .alu_op    (alu_op),
        .halted    (halted),
        .fault     (fault)
    );

    assign obs = {load_ir, inc_pc, load_pc, addr_sel, mem_rd, mem_wr, load_acc, halted, fault, alu_op};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset(input logic [3:0] op, input logic rdy);
        @(negedge clk);
        rst = 1'b1; opcode = op; acc_zero = 1'b0; mem_ready = rdy;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; opcode = 4'h0; acc_zero = 1'b0; mem_ready = 1'b1;
        #1;
        n_checks++;
        if (obs !== 12'h000) begin
            n_fail++; $display("FAIL reset_async obs=%h expected=%h", obs, 12'h000);
        end
        step();
        n_checks++;
        if (obs !== 12'h000) begin
            n_fail++; $display("FAIL reset_held obs=%h expected=%h", obs, 12'h000);
        end
        rst = 1'b0;
    endtask

    task automatic test_program();
        logic [3:0]  prog [4];
        logic [11:0] exp_tr [18];
        int idx;
        prog = '{4'h1, 4'h3, 4'h2, 4'hF};
        exp_tr = '{X_F, X_L, X_D, X_R, X_EPB, X_F, X_L, X_D, X_R, X_EAD,
                   X_F, X_L, X_D, X_W, X_F, X_L, X_D, X_H};
        idx = 0;
        apply_reset(4'h0, 1'b1);
        for (int k = 0; k < 18; k++) begin
            step();
            n_checks++;
            if (obs !== exp_tr[k]) begin
                n_fail++; $display("FAIL program_cycle%0d obs=%h expected=%h", k + 1, obs, exp_tr[k]);
            end
            if (load_ir === 1'b1 && idx < 4) begin
                opcode = prog[idx];
                idx++;
            end
        end
        step(); step();
        n_checks++;
        if (obs !== X_H) begin
            n_fail++; $display("FAIL program_halt_sticky obs=%h expected=%h", obs, X_H);
        end
    endtask

    task automatic test_wait_states();
        int rd_run;
        int ir_pulses;
        logic seen_ir;
        logic bad;
        rd_run = 0; ir_pulses = 0; seen_ir = 1'b0; bad = 1'b0;
        apply_reset(4'h0, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            step();
            if (mem_rd === 1'b1 && !seen_ir) rd_run++;
            if (load_ir === 1'b1) begin
                ir_pulses++; seen_ir = 1'b1; mem_ready = 1'b0;
            end
            if (fault !== 1'b0 || mem_wr !== 1'b0) bad = 1'b1;
            if (c == 4) mem_ready = 1'b1;
        end
        n_checks++;
        if (rd_run != 4) begin
            n_fail++; $display("FAIL wait_mem_rd_len got=%0d expected=4", rd_run);
        end
        n_checks++;
        if (ir_pulses != 1) begin
            n_fail++; $display("FAIL wait_load_ir_pulses got=%0d expected=1", ir_pulses);
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++; $display("FAIL wait_no_fault got=%b expected=0", bad);
        end
    endtask

    task automatic test_timeout();
        int n;
        apply_reset(4'h0, 1'b0);
        step();
        n_checks++;
        if (obs !== X_F) begin
            n_fail++; $display("FAIL timeout_fetch_entry obs=%h expected=%h", obs, X_F);
        end
        n = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (fault === 1'b1) begin
                n = c;
                break;
            end
        end
        n_checks++;
        if (n != 16) begin
            n_fail++; $display("FAIL timeout_cycles got=%0d expected=16", n);
        end
        mem_ready = 1'b1;
        step(); step();
        n_checks++;
        if (obs !== X_FLT) begin
            n_fail++; $display("FAIL timeout_idle obs=%h expected=%h", obs, X_FLT);
        end
        // Ready on the very last permitted wait cycle completes the fetch.
        apply_reset(4'h0, 1'b0);
        step();
        for (int c = 1; c < 16; c++) step();
        mem_ready = 1'b1;
        step();
        n_checks++;
        if (obs !== X_L) begin
            n_fail++; $display("FAIL timeout_boundary_ready obs=%h expected=%h", obs, X_L);
        end
    endtask

    task automatic test_jz();
        logic [11:0] exp_tr [8];
        exp_tr = '{X_F, X_L, X_D, X_J, X_F, X_L, X_D, X_F};
        apply_reset(4'h9, 1'b1);
        acc_zero = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            n_checks++;
            if (obs !== exp_tr[k]) begin
                n_fail++; $display("FAIL jz_cycle%0d obs=%h expected=%h", k + 1, obs, exp_tr[k]);
            end
            if (k == 3) acc_zero = 1'b0;
        end
    endtask

    task automatic test_illegal();
        logic bad;
        bad = 1'b0;
        apply_reset(4'hB, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            step();
            if (load_acc !== 1'b0 || mem_wr !== 1'b0) bad = 1'b1;
            if (k == 4) begin
                n_checks++;
                if (obs !== X_FLT) begin
                    n_fail++; $display("FAIL illegal_fault obs=%h expected=%h", obs, X_FLT);
                end
            end
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++; $display("FAIL illegal_no_strobes got=%b expected=0", bad);
        end
    endtask

    task automatic test_reset_mid_write();
        apply_reset(4'h2, 1'b1);
        step(); step(); step();
        mem_ready = 1'b0;
        step();
        n_checks++;
        if (obs !== X_W) begin
            n_fail++; $display("FAIL midwr_in_mem_wr obs=%h expected=%h", obs, X_W);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (mem_wr !== 1'b0) begin
            n_fail++; $display("FAIL midwr_async_drop got=%b expected=0", mem_wr);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        n_checks++;
        if (obs !== X_F) begin
            n_fail++; $display("FAIL midwr_restart_fetch obs=%h expected=%h", obs, X_F);
        end
    endtask

    initial begin
        rst = 1'b1; opcode = 4'h0; acc_zero = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_program();
        test_wait_states();
        test_timeout();
        test_jz();
        test_illegal();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
